uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
Serialises parallel data words into asynchronous UART frames: start bit, data LSB first, optional parity bit, then 1 or 2 stop bits. It is the upstream stage of the UART receiver and drives the serial line that the receiver samples. Parity generation is paired with the receiver's parity-error detection. Host data enters through a valid/ready handshake.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200 baud); legal range >= 2.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_EN, 1, 1 inserts a parity bit after the data bits; 0 omits it.
PARITY_ODD, 0, 0 selects even parity; 1 selects odd parity. Ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tx_data  input  DATA_BITS  word to transmit; sampled only on the accept edge
tx_valid  input  1  host has a word
tx_ready  output  1  block can accept a word; high only in IDLE
tx  output  1  serial line; idles high; registered
tx_busy  output  1  high while a frame is in progress (any state except IDLE)
tx_done  output  1  one-cycle pulse during the final cycle of the last stop bit

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0, bit counter and baud counter cleared.
- Reset mid-frame: tx returns to 1 immediately and the frame is abandoned. After release the block is in IDLE with no pending word.
- Illegal parameter values cause an elaboration-time error.
- Accept: tx_valid && tx_ready at a clock edge. On that edge:
  - tx_data is latched into a shift register.
  - Parity is computed: even = ^tx_data; odd = ~^tx_data.
  - tx goes to 0 (start bit) and tx_busy goes to 1.
  - tx_ready goes to 0.
- After the accept edge, changes on tx_data and tx_valid have no effect until the block returns to IDLE.
- State sequence: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
- Bit timing:
  - Every bit is held for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps, advancing to the next bit on the wrap.
  - The baud counter restarts at 0 on accept; there is no free-running baud tick.
- DATA state: shifts out DATA_BITS bits, LSB first. A bit index runs 0..DATA_BITS-1.
- STOP state: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length: N = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, measured from the accept edge.
- tx_done is high for exactly one cycle, the Nth cycle of the frame.
- On the edge ending cycle N: state=IDLE, tx_busy=0, tx_ready=1, tx stays 1.
- Back-to-back: if tx_valid is high when tx_ready reasserts, the next word is accepted on the following edge. This gives exactly 1 idle-high cycle between frames (stop bit extended by one cycle). No other gaps are allowed.
- tx_valid held low: the block stays in IDLE with tx=1 indefinitely.
- tx is never X after reset; it changes only on clock edges or on asynchronous reset.

Test Plan:
- CLKS_PER_BIT=4, defaults otherwise. Send 0x55 -> tx is low 4 cycles, then data 1,0,1,0,1,0,1,0 at 4 cycles each, parity 0, stop 1. Frame is 44 cycles. tx_done pulses in cycle 44 and tx_ready is high on the next cycle.
- PARITY_ODD=1, send 0xA5 -> data bits 1,0,1,0,0,1,0,1; parity bit 1. PARITY_EN=0, send 0xA5 -> no parity bit, frame 40 cycles.
- STOP_BITS=2, DATA_BITS=7, send 0x7F -> seven data 1s, parity 1 (even), stop held 8 cycles. Frame 44 cycles. A loopback receiver reports 0x7F with no parity error.
- tx_valid held high with 0x01 then 0x80 -> two frames with exactly 1 idle cycle between the last stop bit and the second start bit. Both words are recovered by the receiver in order.
- Change tx_data 0x3C -> 0xFF two cycles after accept -> the line still carries 0x3C and tx_ready stays 0 until the frame ends.
- Assert rst_n=0 during data bit 3 of 0x0F -> tx=1 immediately, tx_busy=0, tx_ready=1. After release, a new word 0xC3 transmits correctly from the start bit.

Source files
------------

// File: rtl/uart_transmitter.sv
//------------------------------------------------------------------------------
// uart_transmitter
//
// Serialises parallel words into asynchronous UART frames:
//   start bit (0), DATA_BITS data bits LSB first, optional parity bit,
//   STOP_BITS stop bits (1). Each bit lasts exactly CLKS_PER_BIT clocks.
// A word is accepted through a valid/ready handshake and is held internally,
// so the host may change tx_data / tx_valid freely once the frame has started.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (>= 2)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY_EN     1 = parity bit after the data bits, 0 = none
//   PARITY_ODD    0 = even parity, 1 = odd parity (ignored if PARITY_EN = 0)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   tx_data   word to transmit, sampled only on the accept edge
//   tx_valid  host has a word
//   tx_ready  block can accept a word (high only in IDLE)
//   tx        serial line, idles high, registered
//   tx_busy   frame in progress (any state except IDLE)
//   tx_done   one-cycle pulse during the final cycle of the last stop bit
//
// States:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | line high, tx_ready high, waiting for tx_valid
//   S_START  | driving the start bit (0)
//   S_DATA   | shifting out data bits, LSB first, bit_idx = data bit number
//   S_PARITY | driving the parity bit captured at accept
//   S_STOP   | driving stop bit(s) (1), bit_idx = stop bit number
//------------------------------------------------------------------------------
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // Parameter legality, reported at elaboration time.
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_transmitter: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_transmitter: DATA_BITS must be in 5..9");
    end
    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
        $error("uart_transmitter: PARITY_EN must be 0 or 1");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_transmitter: PARITY_ODD must be 0 or 1");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_transmitter: STOP_BITS must be 1 or 2");
    end

    localparam int CNT_W = (CLKS_PER_BIT >= 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = 4;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    // tx_done is registered, so it is raised one count before the final one
    // in order to be visible during the last cycle of the frame.
    localparam logic [CNT_W-1:0] CNT_PRE    = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST  = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;
    logic                 bit_end;

    assign bit_end = (baud_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // tx_ready is high throughout IDLE, so tx_valid alone
                    // completes the handshake here.
                    if (tx_valid) begin
                        shift_reg  <= tx_data;
                        parity_bit <= (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
                        tx         <= 1'b0;
                        tx_busy    <= 1'b1;
                        tx_ready   <= 1'b0;
                        baud_cnt   <= '0;
                        bit_idx    <= '0;
                        state      <= S_START;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                tx    <= parity_bit;
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            bit_idx   <= bit_idx + IDX_W'(1);
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                S_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (bit_idx == STOP_LAST && baud_cnt == CNT_PRE) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx  <= '0;
                            tx_busy  <= 1'b0;
                            tx_ready <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    tx       <= 1'b1;
                    tx_busy  <= 1'b0;
                    tx_ready <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

    localparam int NCFG = 4;
    localparam int CPB  = 4;
    // cfg0: defaults, cfg1: odd parity, cfg2: no parity, cfg3: 7 data bits + 2 stop
    localparam int DB [NCFG] = '{8, 8, 8, 7};
    localparam int PE [NCFG] = '{1, 1, 0, 1};
    localparam int PO [NCFG] = '{0, 1, 0, 0};
    localparam int SB [NCFG] = '{1, 1, 1, 2};

    logic            clk = 1'b0;
    logic [NCFG-1:0] rst_v;
    logic [NCFG-1:0] valid_in;
    logic [8:0]      data_in [NCFG];
    logic [NCFG-1:0] tx_o, ready_o, busy_o, done_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W = DB[g];
        localparam int N = (1 + DB[g] + PE[g] + SB[g]) * CPB;

        uart_transmitter #(
            .CLKS_PER_BIT(CPB),
            .DATA_BITS   (DB[g]),
            .PARITY_EN   (PE[g]),
            .PARITY_ODD  (PO[g]),
            .STOP_BITS   (SB[g])
        ) dut (
            .clk     (clk),
            .rst_n   (rst_v[g]),
            .tx_data (data_in[g][W-1:0]),
            .tx_valid(valid_in[g]),
            .tx_ready(ready_o[g]),
            .tx      (tx_o[g]),
            .tx_busy (busy_o[g]),
            .tx_done (done_o[g])
        );

        // Model: k = cycle number within the current frame (1..N), 0 = idle.
        int         k;
        logic [8:0] wm;

        function automatic logic exp_bit(input int p, input logic [8:0] w);
            logic [W-1:0] d;
            d = w[W-1:0];
            if (p == 0) return 1'b0;
            if (p <= W) return d[p-1];
            if (PE[g] == 1 && p == W + 1) return (PO[g] == 1) ? ~^d : ^d;
            return 1'b1;
        endfunction

        always @(posedge clk or negedge rst_v[g]) begin
            if (!rst_v[g]) begin
                k <= 0;
            end else if (k == 0) begin
                if (valid_in[g]) begin
                    k  <= 1;
                    wm <= data_in[g];
                end
            end else if (k == N) begin
                k <= 0;
            end else begin
                k <= k + 1;
            end
        end

        always @(negedge clk) begin
            check($sformatf("cfg%0d tx k=%0d", g, k), tx_o[g],
                  (k == 0) ? 1'b1 : exp_bit((k - 1) / CPB, wm));
            check($sformatf("cfg%0d busy k=%0d", g, k), busy_o[g], k != 0);
            check($sformatf("cfg%0d ready k=%0d", g, k), ready_o[g], k == 0);
            check($sformatf("cfg%0d done k=%0d", g, k), done_o[g], k == N);
        end
    end

    // Called at the negedge of cycle 1 of a frame; samples every bit mid-period
    // and returns the cycle number in which tx_done was seen (0 if never).
    task automatic capture(input int i, input bit chg, output logic [15:0] bits, output int len);
        bits = '1;
        len  = 0;
        for (int c = 1; c <= 200 && len == 0; c++) begin
            if ((c % CPB) == 2 && (c / CPB) < 16) bits[c/CPB] = tx_o[i];
            if (chg && c == 2) begin
                data_in[i] = 9'h0FF;
                check("hold ready low", ready_o[i], 1'b0);
            end
            if (done_o[i]) len = c;
            if (len == 0) @(negedge clk);
        end
    endtask

    task automatic send(input int i, input logic [8:0] w, input bit chg,
                        output logic [15:0] bits, output int len);
        @(negedge clk);
        data_in[i]  = w;
        valid_in[i] = 1'b1;
        @(negedge clk);
        valid_in[i] = 1'b0;
        capture(i, chg, bits, len);
    endtask

    task automatic reset_mid(input int i, input logic [8:0] w, input int cyc);
        @(negedge clk);
        data_in[i]  = w;
        valid_in[i] = 1'b1;
        @(negedge clk);
        valid_in[i] = 1'b0;
        repeat (cyc - 1) @(negedge clk);
        #2 rst_v[i] = 1'b0;
        #1;
        check($sformatf("cfg%0d rst tx", i), tx_o[i], 1'b1);
        check($sformatf("cfg%0d rst busy", i), busy_o[i], 1'b0);
        check($sformatf("cfg%0d rst ready", i), ready_o[i], 1'b1);
        check($sformatf("cfg%0d rst done", i), done_o[i], 1'b0);
        @(negedge clk);
        #2 rst_v[i] = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, actual %0t, required below 100000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bits;
        int          len;

        rst_v    = '0;
        valid_in = '0;
        for (int i = 0; i < NCFG; i++) data_in[i] = '0;
        #22 rst_v = '1;
        repeat (3) @(negedge clk);
        check("reset tx", tx_o[0], 1'b1);
        check("reset ready", ready_o[0], 1'b1);

        send(0, 9'h055, 1'b0, bits, len);
        check("cfg0 0x55 bits", bits[10:0], 11'b10010101010);
        check("cfg0 0x55 len", len, 44);
        @(negedge clk);
        check("cfg0 ready after frame", ready_o[0], 1'b1);

        send(1, 9'h0A5, 1'b0, bits, len);
        check("cfg1 odd 0xA5 bits", bits[10:0], 11'b11101001010);
        check("cfg1 odd 0xA5 len", len, 44);

        send(2, 9'h0A5, 1'b0, bits, len);
        check("cfg2 nopar 0xA5 bits", bits[9:0], 10'b1101001010);
        check("cfg2 nopar 0xA5 len", len, 40);

        send(3, 9'h07F, 1'b0, bits, len);
        check("cfg3 7b2s 0x7F bits", bits[10:0], 11'b11111111110);
        check("cfg3 7b2s 0x7F len", len, 44);

        send(0, 9'h03C, 1'b1, bits, len);
        check("cfg0 hold 0x3C bits", bits[10:0], 11'b10001111000);
        check("cfg0 hold 0x3C len", len, 44);

        // Back-to-back with tx_valid held high.
        @(negedge clk);
        data_in[0]  = 9'h001;
        valid_in[0] = 1'b1;
        @(negedge clk);
        data_in[0] = 9'h080;
        capture(0, 1'b0, bits, len);
        check("b2b first bits", bits[10:0], 11'b11000000010);
        check("b2b first len", len, 44);
        @(negedge clk);
        check("b2b gap tx", tx_o[0], 1'b1);
        check("b2b gap ready", ready_o[0], 1'b1);
        @(negedge clk);
        check("b2b second start tx", tx_o[0], 1'b0);
        check("b2b second busy", busy_o[0], 1'b1);
        valid_in[0] = 1'b0;
        capture(0, 1'b0, bits, len);
        check("b2b second bits", bits[10:0], 11'b11100000000);
        check("b2b second len", len, 44);

        // Reset during data bit 3 of 0x0F, then a clean frame.
        reset_mid(0, 9'h00F, 18);
        send(0, 9'h0C3, 1'b0, bits, len);
        check("cfg0 after rst 0xC3 bits", bits[10:0], 11'b10110000110);
        check("cfg0 after rst 0xC3 len", len, 44);

        // Reset during the start bit, where the line is low.
        reset_mid(1, 9'h0C3, 2);
        send(1, 9'h0C3, 1'b0, bits, len);
        check("cfg1 after rst 0xC3 len", len, 44);

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
